key_conditioner: RTL

Conditions raw active-low push-button inputs (KEY0–KEY3) into clean, clock-synchronous events for the demo FSMs that consume them, e.g. the "continue" key that advances operand/opcode/result display states. Per key: 2-FF synchronizer, debounce filter, and a press/hold/release state machine with optional auto-repeat. Consumers see exactly one `press_pulse` per physical press instead of a raw level sampled every cycle.

---
 rtl/key_conditioner.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/key_conditioner.sv
// Per-key push-button conditioning: 2-FF synchronizer, debounce filter and a
// press/hold/repeat state machine producing one-cycle event pulses.
module key_conditioner #(
    parameter int NKEYS           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NKEYS-1:0] key_n,
    input  logic [NKEYS-1:0] repeat_en,
    output logic [NKEYS-1:0] key_level,
    output logic [NKEYS-1:0] press_pulse,
    output logic [NKEYS-1:0] release_pulse,
    output logic [NKEYS-1:0] repeat_pulse
);

    localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int HW   = (HMAX > 1) ? $clog2(HMAX) : 1;

    // Counters hold "cycles already seen"; the last value triggers the event.
    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] DELAY_LAST = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0] RATE_LAST  = HW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        ST_RELEASED  = 2'd0,
        ST_HELD      = 2'd1,
        ST_REPEATING = 2'd2
    } key_state_t;

    logic [NKEYS-1:0]         sync1_q, sync1_d;
    logic [NKEYS-1:0]         sync2_q, sync2_d;
    logic [NKEYS-1:0]         level_q, level_d;
    logic [NKEYS-1:0][DW-1:0] db_cnt_q, db_cnt_d;
    logic [NKEYS-1:0][HW-1:0] hc_q, hc_d;
    key_state_t               state_q [NKEYS];
    key_state_t               state_d [NKEYS];
    logic [NKEYS-1:0]         press_q, press_d;
    logic [NKEYS-1:0]         release_q, release_d;
    logic [NKEYS-1:0]         repeat_q, repeat_d;
    logic [NKEYS-1:0]         key_s;

    assign key_s = ~sync2_q;

    always_comb begin
        sync1_d   = key_n;
        sync2_d   = sync1_q;
        level_d   = level_q;
        db_cnt_d  = db_cnt_q;
        hc_d      = hc_q;
        state_d   = state_q;
        press_d   = '0;
        release_d = '0;
        repeat_d  = '0;
        for (int i = 0; i < NKEYS; i++) begin
            // Any sample agreeing with the accepted level restarts the filter.
            if (key_s[i] == level_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                level_d[i]  = key_s[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end

            // The FSM looks at the level being accepted this edge so that
            // press/release pulses line up with the first cycle of the new level.
            case (state_q[i])
                ST_RELEASED: begin
                    if (level_d[i] && !level_q[i]) begin
                        press_d[i] = 1'b1;
                        hc_d[i]    = '0;
                        state_d[i] = ST_HELD;
                    end
                end
                ST_HELD: begin
                    if (!level_d[i] && level_q[i]) begin
                        release_d[i] = 1'b1;
                        state_d[i]   = ST_RELEASED;
                    end else if (!repeat_en[i]) begin
                        hc_d[i] = '0;
                    end else if (hc_q[i] == DELAY_LAST) begin
                        repeat_d[i] = 1'b1;
                        hc_d[i]     = '0;
                        state_d[i]  = ST_REPEATING;
                    end else begin
                        hc_d[i] = hc_q[i] + 1'b1;
                    end
                end
                ST_REPEATING: begin
                    if (!level_d[i] && level_q[i]) begin
                        release_d[i] = 1'b1;
                        state_d[i]   = ST_RELEASED;
                    end else if (!repeat_en[i]) begin
                        hc_d[i]    = '0;
                        state_d[i] = ST_HELD;
                    end else if (hc_q[i] == RATE_LAST) begin
                        repeat_d[i] = 1'b1;
                        hc_d[i]     = '0;
                    end else begin
                        hc_d[i] = hc_q[i] + 1'b1;
                    end
                end
                default: begin
                    state_d[i] = ST_RELEASED;
                    hc_d[i]    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            level_q   <= '0;
            db_cnt_q  <= '0;
            hc_q      <= '0;
            press_q   <= '0;
            release_q <= '0;
            repeat_q  <= '0;
            for (int i = 0; i < NKEYS; i++) begin
                state_q[i] <= ST_RELEASED;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            level_q   <= level_d;
            db_cnt_q  <= db_cnt_d;
            hc_q      <= hc_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
            for (int i = 0; i < NKEYS; i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

    assign key_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign repeat_pulse  = repeat_q;

endmodule
